// File: rtl/pipeline_hazard_scheduler.sv
// Hazard scheduler for a decode/execute/memory/writeback pipeline: tracks in-flight
// destinations in E/M/W slots and produces load-use stalls, redirect squashes and forward selects.
module pipeline_hazard_scheduler #(
    parameter int REGISTER_SIZE = 5,
    parameter int PERF_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d_valid,
    input  logic [REGISTER_SIZE-1:0] d_rs1,
    input  logic [REGISTER_SIZE-1:0] d_rs2,
    input  logic                     d_rs1_used,
    input  logic                     d_rs2_used,
    input  logic [REGISTER_SIZE-1:0] d_rd,
    input  logic                     d_reg_write,
    input  logic                     d_is_load,
    input  logic                     d_redirect,
    output logic                     f_to_d_enable_ff,
    output logic                     d_to_e_enable_ff,
    output logic                     d_to_e_bubble,
    output logic                     f_to_d_flush,
    output logic [1:0][1:0]          pipeline_forward_sel,
    output logic [PERF_WIDTH-1:0]    stall_cycles,
    output logic [PERF_WIDTH-1:0]    flush_cycles
);

    // Slot index 0 = E, 1 = M, 2 = W.
    logic [2:0]               r_slot_valid;
    logic [2:0]               r_slot_load;
    logic [REGISTER_SIZE-1:0] r_slot_rd [3];

    logic [1:0][1:0]          r_fwd_sel;
    logic [PERF_WIDTH-1:0]    r_stall_cycles;
    logic [PERF_WIDTH-1:0]    r_flush_cycles;

    logic [REGISTER_SIZE-1:0] w_src [2];
    logic [1:0]               w_src_used;
    logic [1:0][2:0]          w_match;
    logic [1:0][1:0]          w_sel;
    logic                     w_stall;
    logic                     w_redirect;
    logic                     w_new_valid;
    logic                     w_fwd_load;

    assign w_src[0]      = d_rs1;
    assign w_src[1]      = d_rs2;
    assign w_src_used[0] = d_rs1_used;
    assign w_src_used[1] = d_rs2_used;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            for (gj = 0; gj < 3; gj++) begin : g_slot
                assign w_match[gi][gj] = w_src_used[gi] && (w_src[gi] != '0) &&
                                         r_slot_valid[gj] && (r_slot_rd[gj] == w_src[gi]);
            end
            // Youngest producer wins; an E-slot load match never reaches execute (it stalls).
            assign w_sel[gi] = w_match[gi][0] ? 2'b01 :
                               w_match[gi][1] ? 2'b10 :
                               w_match[gi][2] ? 2'b11 : 2'b00;
        end
    endgenerate

    assign w_stall     = d_valid && (w_match[0][0] || w_match[1][0]) && r_slot_load[0];
    assign w_redirect  = d_valid && d_redirect && !w_stall;
    assign w_new_valid = d_valid && !w_stall && d_reg_write && (d_rd != '0);

    // Combinational controls read as reset values while rst is held.
    assign f_to_d_enable_ff = rst || !w_stall;
    assign d_to_e_enable_ff = 1'b1;
    assign d_to_e_bubble    = !rst && w_stall;
    assign f_to_d_flush     = !rst && w_redirect;
    assign w_fwd_load       = d_to_e_enable_ff && !d_to_e_bubble && d_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_valid   <= '0;
            r_slot_load    <= '0;
            for (int i = 0; i < 3; i++) r_slot_rd[i] <= '0;
            r_fwd_sel      <= '0;
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            r_slot_valid <= {r_slot_valid[1:0], w_new_valid};
            r_slot_load  <= {r_slot_load[1:0], w_new_valid && d_is_load};
            r_slot_rd[2] <= r_slot_rd[1];
            r_slot_rd[1] <= r_slot_rd[0];
            r_slot_rd[0] <= d_rd;
            r_fwd_sel    <= w_fwd_load ? w_sel : '0;
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_redirect && (r_flush_cycles != '1))
                r_flush_cycles <= r_flush_cycles + 1'b1;
        end
    end

    assign pipeline_forward_sel = r_fwd_sel;
    assign stall_cycles         = r_stall_cycles;
    assign flush_cycles         = r_flush_cycles;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Table-driven bench for pipeline_hazard_scheduler; a narrow-counter second instance
// shares the stimulus so counter saturation is reachable in a short run.
module tb_pipeline_hazard_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       d_valid, d_rs1_used, d_rs2_used, d_reg_write, d_is_load, d_redirect;
    logic [4:0] d_rs1, d_rs2, d_rd;

    logic            f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble, f_to_d_flush;
    logic [1:0][1:0] pipeline_forward_sel;
    logic [15:0]     stall_cycles, flush_cycles;

    logic            s_fd_en, s_de_en, s_bubble, s_flush;
    logic [1:0][1:0] s_sel;
    logic [3:0]      s_stall_cycles, s_flush_cycles;

    pipeline_hazard_scheduler #(.REGISTER_SIZE(5), .PERF_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd),
        .d_reg_write(d_reg_write), .d_is_load(d_is_load), .d_redirect(d_redirect),
        .f_to_d_enable_ff(f_to_d_enable_ff), .d_to_e_enable_ff(d_to_e_enable_ff),
        .d_to_e_bubble(d_to_e_bubble), .f_to_d_flush(f_to_d_flush),
        .pipeline_forward_sel(pipeline_forward_sel),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    pipeline_hazard_scheduler #(.REGISTER_SIZE(5), .PERF_WIDTH(4)) u_dut_sat (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd),
        .d_reg_write(d_reg_write), .d_is_load(d_is_load), .d_redirect(d_redirect),
        .f_to_d_enable_ff(s_fd_en), .d_to_e_enable_ff(s_de_en),
        .d_to_e_bubble(s_bubble), .f_to_d_flush(s_flush),
        .pipeline_forward_sel(s_sel),
        .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       redir;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_s1;
        logic [1:0] e_s2;
        int         e_sc;
        int         e_fc;
        string      name;
    } vec_t;

    typedef struct {
        logic [1:0] s1;
        logic [1:0] s2;
        int         sc;
        int         fc;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic wr, input logic ld,
                                input logic rdir, input logic st, input logic fl,
                                input logic [1:0] s1, input logic [1:0] s2,
                                input int sc, input int fc, input string nm);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
        r.rd = 5'(rd); r.wr = wr; r.ld = ld; r.redir = rdir;
        r.e_stall = st; r.e_flush = fl; r.e_s1 = s1; r.e_s2 = s2;
        r.e_sc = sc; r.e_fc = fc; r.name = nm;
        return r;
    endfunction

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Called at posedge+1: drive one decode slot, check the controls mid-cycle,
    // then check the registered selects and counters after the edge.
    task automatic apply(input vec_t t);
        exp_t e;
        d_valid = t.v; d_rs1 = t.rs1; d_rs1_used = t.u1; d_rs2 = t.rs2; d_rs2_used = t.u2;
        d_rd = t.rd; d_reg_write = t.wr; d_is_load = t.ld; d_redirect = t.redir;
        sbq.push_back('{t.e_s1, t.e_s2, t.e_sc, t.e_fc, t.name});
        @(negedge clk);
        chk({t.name, ".fd_en"},  32'(f_to_d_enable_ff), 32'(!t.e_stall));
        chk({t.name, ".bubble"}, 32'(d_to_e_bubble),    32'(t.e_stall));
        chk({t.name, ".flush"},  32'(f_to_d_flush),     32'(t.e_flush));
        chk({t.name, ".de_en"},  32'(d_to_e_enable_ff), 32'd1);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.name, ".sel0"},   32'(pipeline_forward_sel[0]), 32'(e.s1));
        chk({e.name, ".sel1"},   32'(pipeline_forward_sel[1]), 32'(e.s2));
        chk({e.name, ".stalls"}, 32'(stall_cycles),   32'(e.sc));
        chk({e.name, ".flushes"},32'(flush_cycles),   32'(e.fc));
        chk({e.name, ".sat_st"}, 32'(s_stall_cycles), 32'(sat15(e.sc)));
        chk({e.name, ".sat_fl"}, 32'(s_flush_cycles), 32'(sat15(e.fc)));
        $display("txn %s: fd_en=%0b bubble=%0b flush=%0b sel=%0d/%0d stalls=%0d flushes=%0d",
                 e.name, f_to_d_enable_ff, d_to_e_bubble, f_to_d_flush,
                 pipeline_forward_sel[0], pipeline_forward_sel[1], stall_cycles, flush_cycles);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".fd_en"},  32'(f_to_d_enable_ff), 32'd1);
        chk({nm, ".de_en"},  32'(d_to_e_enable_ff), 32'd1);
        chk({nm, ".bubble"}, 32'(d_to_e_bubble),    32'd0);
        chk({nm, ".flush"},  32'(f_to_d_flush),     32'd0);
        chk({nm, ".sat_bubble"}, 32'(s_bubble),     32'd0);
    endtask

    vec_t tbl [23];
    vec_t lws;
    int   sc_exp;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {v, rs1,u1, rs2,u2, rd,wr,ld,redir, stall,flush, sel0,sel1, stalls,flushes}
        tbl[0]  = mk(1, 1,1, 2,1,  5,1,0,0, 0,0, 2'b00,2'b00, 0,0, "alu_add_x5");
        tbl[1]  = mk(1, 5,1, 2,1,  6,1,0,0, 0,0, 2'b01,2'b00, 0,0, "alu_fwd_e");
        tbl[2]  = mk(1, 1,1, 0,0,  7,1,1,0, 0,0, 2'b00,2'b00, 0,0, "lw_x7");
        tbl[3]  = mk(1, 7,1, 7,1,  8,1,0,0, 1,0, 2'b00,2'b00, 1,0, "loaduse_stall");
        tbl[4]  = mk(1, 7,1, 7,1,  8,1,0,0, 0,0, 2'b10,2'b10, 1,0, "loaduse_retry");
        tbl[5]  = mk(1, 0,1, 0,0,  3,1,0,0, 0,0, 2'b00,2'b00, 1,0, "addi_x3");
        tbl[6]  = mk(1, 11,1, 12,1, 10,1,0,0, 0,0, 2'b00,2'b00, 1,0, "indep_a");
        tbl[7]  = mk(1, 14,1, 15,1, 13,1,0,0, 0,0, 2'b00,2'b00, 1,0, "indep_b");
        tbl[8]  = mk(1, 3,1, 3,0,  0,1,0,0, 0,0, 2'b11,2'b00, 1,0, "dist3_w");
        tbl[9]  = mk(1, 0,0, 3,1, 16,1,0,0, 0,0, 2'b00,2'b00, 1,0, "dist4_rf");
        tbl[10] = mk(1, 0,1, 0,0,  4,1,0,0, 0,0, 2'b00,2'b00, 1,0, "addi_x4_a");
        tbl[11] = mk(1, 0,1, 0,0,  4,1,0,0, 0,0, 2'b00,2'b00, 1,0, "addi_x4_b");
        tbl[12] = mk(1, 4,1, 4,1, 17,1,0,0, 0,0, 2'b01,2'b01, 1,0, "prio_e_over_m");
        tbl[13] = mk(1, 4,1, 17,1, 0,0,0,0, 0,0, 2'b10,2'b01, 1,0, "prio_m_over_w");
        tbl[14] = mk(1, 20,1, 21,1, 0,0,0,1, 0,1, 2'b00,2'b00, 1,1, "beq_taken");
        tbl[15] = mk(0, 0,0, 0,0,  0,0,0,1, 0,0, 2'b00,2'b00, 1,1, "redir_invalid");
        tbl[16] = mk(1, 1,1, 0,0,  9,1,1,0, 0,0, 2'b00,2'b00, 1,1, "lw_x9");
        tbl[17] = mk(1, 9,1, 0,1,  0,0,0,1, 1,0, 2'b00,2'b00, 2,1, "beq_stall");
        tbl[18] = mk(1, 9,1, 0,1,  0,0,0,1, 0,1, 2'b10,2'b00, 2,2, "beq_retry_flush");
        tbl[19] = mk(1, 1,1, 0,0,  0,1,1,0, 0,0, 2'b00,2'b00, 2,2, "lw_x0");
        tbl[20] = mk(1, 0,1, 0,1,  0,1,0,0, 0,0, 2'b00,2'b00, 2,2, "read_x0");
        tbl[21] = mk(1, 1,1, 0,0, 22,0,1,0, 0,0, 2'b00,2'b00, 2,2, "load_nowrite");
        tbl[22] = mk(1, 22,1, 0,0, 0,0,0,0, 0,0, 2'b00,2'b00, 2,2, "read_nowrite");

        // Reset with a live redirect on the inputs: everything must read reset values.
        rst = 1'b1;
        d_valid = 1'b1; d_rs1 = 5'd1; d_rs2 = 5'd2; d_rs1_used = 1'b1; d_rs2_used = 1'b1;
        d_rd = 5'd3; d_reg_write = 1'b1; d_is_load = 1'b1; d_redirect = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk_reset_outputs("reset");
        chk("reset.sel0",    32'(pipeline_forward_sel[0]), 32'd0);
        chk("reset.sel1",    32'(pipeline_forward_sel[1]), 32'd0);
        chk("reset.stalls",  32'(stall_cycles), 32'd0);
        chk("reset.flushes", 32'(flush_cycles), 32'd0);
        $display("txn reset: fd_en=%0b bubble=%0b flush=%0b", f_to_d_enable_ff, d_to_e_bubble, f_to_d_flush);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) apply(tbl[i]);

        // Self-dependent load repeated: stalls every other cycle, saturating the narrow counters.
        sc_exp = 2;
        for (int k = 0; k < 38; k++) begin
            if (k % 2 == 1) sc_exp++;
            lws = mk(1, 7,1, 0,0, 7,1,1,0, (k % 2 == 1), 0,
                     ((k % 2 == 0) && (k > 0)) ? 2'b10 : 2'b00, 2'b00, sc_exp, 2, $sformatf("sat_%0d", k));
            apply(lws);
        end
        chk("sat.narrow_stalls", 32'(s_stall_cycles), 32'd15);
        chk("sat.wide_stalls",   32'(stall_cycles),   32'd21);

        lws = mk(1, 7,1, 0,0, 7,1,1,0, 0,0, 2'b10,2'b00, 21,2, "prestall");
        apply(lws);

        // Enter a stall, then assert reset in the middle of it.
        d_valid = 1'b1; d_rs1 = 5'd7; d_rs1_used = 1'b1; d_rs2_used = 1'b0;
        d_rd = 5'd7; d_reg_write = 1'b1; d_is_load = 1'b1; d_redirect = 1'b1;
        @(negedge clk);
        chk("midstall.fd_en",  32'(f_to_d_enable_ff), 32'd0);
        chk("midstall.bubble", 32'(d_to_e_bubble),    32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_forced");
        @(posedge clk); #1;
        chk_reset_outputs("rst_applied");
        chk("rst_applied.sel0",    32'(pipeline_forward_sel[0]), 32'd0);
        chk("rst_applied.stalls",  32'(stall_cycles),   32'd0);
        chk("rst_applied.flushes", 32'(flush_cycles),   32'd0);
        chk("rst_applied.sat_st",  32'(s_stall_cycles), 32'd0);
        $display("txn rst_midstall: fd_en=%0b bubble=%0b stalls=%0d", f_to_d_enable_ff, d_to_e_bubble, stall_cycles);
        rst = 1'b0;

        lws = mk(1, 7,1, 0,0, 7,1,1,0, 0,0, 2'b00,2'b00, 0,0, "post_rst_clear");
        apply(lws);
        lws = mk(1, 7,1, 0,0, 7,1,1,0, 1,0, 2'b00,2'b00, 1,0, "post_rst_stall");
        apply(lws);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
